// File: rtl/traffic_light_monitor.sv
// Passive safety checker for the six T-junction lamp buses: encoding, sequencing,
// dwell and conflict rules, with sticky flags, first-fault id and a saturating count.
module traffic_light_monitor #(
    parameter int unsigned MIN_GREEN  = 5,
    parameter int unsigned MIN_YELLOW = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] w_to_e,
    input  logic [2:0] w_to_n,
    input  logic [2:0] e_to_w,
    input  logic [2:0] e_to_n,
    input  logic [2:0] n_to_e,
    input  logic [2:0] n_to_w,
    input  logic       clr_err,
    output logic       err_encoding,
    output logic       err_sequence,
    output logic       err_dwell,
    output logic       err_conflict,
    output logic       fault,
    output logic [2:0] fault_id,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {
        LAMP_RED = 3'b100,
        LAMP_YEL = 3'b010,
        LAMP_GRN = 3'b001
    } lamp_e;

    logic [2:0]       w_code     [6];
    logic [2:0]       w_prev_nxt [6];
    logic [CNT_W-1:0] w_cnt_nxt  [6];
    logic [2:0]       r_prev     [6];
    logic [CNT_W-1:0] r_cnt      [6];
    logic             r_armed;

    logic [5:0] w_enc_bad, w_seq_bad, w_dwell_bad, w_conf_lo, w_nonred;
    logic       w_any, w_fault_base;
    logic [2:0] w_new_id;
    logic [7:0] w_cnt_base;

    logic       r_err_enc, r_err_seq, r_err_dwell, r_err_conf;
    logic [2:0] r_fault_id;
    logic [7:0] r_err_count;

    assign w_code[0] = w_to_e;
    assign w_code[1] = w_to_n;
    assign w_code[2] = e_to_w;
    assign w_code[3] = e_to_n;
    assign w_code[4] = n_to_e;
    assign w_code[5] = n_to_w;

    function automatic logic [2:0] lowest_set(input logic [5:0] v);
        logic [2:0] idx;
        idx = 3'd7;
        for (int unsigned i = 0; i < 6; i++) begin
            if (v[i] && idx == 3'd7) idx = 3'(i);
        end
        return idx;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < 6; i++) begin
            w_enc_bad[i]   = !(w_code[i] == LAMP_RED || w_code[i] == LAMP_YEL || w_code[i] == LAMP_GRN);
            w_nonred[i]    = (w_code[i] == LAMP_YEL) || (w_code[i] == LAMP_GRN);
            w_seq_bad[i]   = 1'b0;
            w_dwell_bad[i] = 1'b0;
            w_prev_nxt[i]  = r_prev[i];
            w_cnt_nxt[i]   = r_cnt[i];
            // Illegal codes freeze that signal's history so the next legal code is judged against the last good one
            if (!w_enc_bad[i]) begin
                if (!r_armed || w_code[i] != r_prev[i]) begin
                    w_prev_nxt[i] = w_code[i];
                    w_cnt_nxt[i]  = CNT_W'(1);
                    if (r_armed) begin
                        if (r_prev[i] == LAMP_RED && w_code[i] == LAMP_GRN) begin
                            w_seq_bad[i] = 1'b0;
                        end else if (r_prev[i] == LAMP_GRN && w_code[i] == LAMP_YEL) begin
                            w_dwell_bad[i] = r_cnt[i] < CNT_W'(MIN_GREEN);
                        end else if (r_prev[i] == LAMP_YEL && w_code[i] == LAMP_RED) begin
                            w_dwell_bad[i] = r_cnt[i] < CNT_W'(MIN_YELLOW);
                        end else begin
                            w_seq_bad[i] = 1'b1;
                        end
                    end
                end else if (r_cnt[i] != '1) begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Each conflict is attributed to the lower index of its pair
    assign w_conf_lo[0] = w_nonred[0] & (w_nonred[3] | w_nonred[4] | w_nonred[5]);
    assign w_conf_lo[1] = w_nonred[1] & (w_nonred[2] | w_nonred[3] | w_nonred[5]);
    assign w_conf_lo[2] = w_nonred[2] & w_nonred[5];
    assign w_conf_lo[3] = w_nonred[3] & w_nonred[5];
    assign w_conf_lo[4] = 1'b0;
    assign w_conf_lo[5] = 1'b0;

    assign w_any = |{w_enc_bad, w_conf_lo, w_seq_bad, w_dwell_bad};

    always_comb begin
        w_new_id = 3'd7;
        if (|w_enc_bad)        w_new_id = lowest_set(w_enc_bad);
        else if (|w_conf_lo)   w_new_id = lowest_set(w_conf_lo);
        else if (|w_seq_bad)   w_new_id = lowest_set(w_seq_bad);
        else if (|w_dwell_bad) w_new_id = lowest_set(w_dwell_bad);
    end

    assign w_fault_base = fault & !clr_err;
    assign w_cnt_base   = clr_err ? '0 : r_err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 6; i++) begin
                r_prev[i] <= LAMP_RED;
                r_cnt[i]  <= '0;
            end
            r_armed     <= 1'b0;
            r_err_enc   <= 1'b0;
            r_err_seq   <= 1'b0;
            r_err_dwell <= 1'b0;
            r_err_conf  <= 1'b0;
            r_fault_id  <= 3'd7;
            r_err_count <= '0;
        end else begin
            for (int unsigned i = 0; i < 6; i++) begin
                r_prev[i] <= w_prev_nxt[i];
                r_cnt[i]  <= w_cnt_nxt[i];
            end
            r_armed     <= 1'b1;
            r_err_enc   <= (r_err_enc   & !clr_err) | (|w_enc_bad);
            r_err_seq   <= (r_err_seq   & !clr_err) | (|w_seq_bad);
            r_err_dwell <= (r_err_dwell & !clr_err) | (|w_dwell_bad);
            r_err_conf  <= (r_err_conf  & !clr_err) | (|w_conf_lo);
            if (w_any && !w_fault_base) r_fault_id <= w_new_id;
            else if (clr_err)           r_fault_id <= 3'd7;
            r_err_count <= w_cnt_base + {7'd0, (w_any && w_cnt_base != '1)};
        end
    end

    assign err_encoding = r_err_enc;
    assign err_sequence = r_err_seq;
    assign err_dwell    = r_err_dwell;
    assign err_conflict = r_err_conf;
    assign fault        = r_err_enc | r_err_seq | r_err_dwell | r_err_conf;
    assign fault_id     = r_fault_id;
    assign err_count    = r_err_count;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench: a behavioural model predicts each cycle's outputs at drive time,
// a monitor pops and compares them one step after every rising edge.
module tb_traffic_light_monitor;

    localparam int unsigned MIN_GREEN  = 5;
    localparam int unsigned MIN_YELLOW = 2;
    localparam int unsigned CNT_W      = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_err = 1'b0;
    logic [2:0] s_code [6];
    logic       err_encoding, err_sequence, err_dwell, err_conflict, fault;
    logic [2:0] fault_id;
    logic [7:0] err_count;

    traffic_light_monitor #(.MIN_GREEN(MIN_GREEN), .MIN_YELLOW(MIN_YELLOW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .w_to_e(s_code[0]), .w_to_n(s_code[1]), .e_to_w(s_code[2]),
        .e_to_n(s_code[3]), .n_to_e(s_code[4]), .n_to_w(s_code[5]),
        .clr_err(clr_err),
        .err_encoding(err_encoding), .err_sequence(err_sequence), .err_dwell(err_dwell),
        .err_conflict(err_conflict), .fault(fault), .fault_id(fault_id), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int enc, seq, dw, conf, flt, id, cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [2:0] m_prev [6];
    int         m_cnt  [6];
    bit         m_armed;
    int         m_enc, m_seq, m_dw, m_conf, m_id, m_count;
    int         pair_a [8] = '{0, 0, 0, 1, 1, 1, 2, 3};
    int         pair_b [8] = '{3, 4, 5, 2, 3, 5, 5, 5};

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [2:0] c);
        return c == 3'b100 || c == 3'b010 || c == 3'b001;
    endfunction

    function automatic bit is_lit(input logic [2:0] c);
        return c == 3'b010 || c == 3'b001;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_prev[i] = 3'b100;
            m_cnt[i]  = 0;
        end
        m_armed = 0;
        m_enc = 0; m_seq = 0; m_dw = 0; m_conf = 0; m_id = 7; m_count = 0;
    endtask

    task automatic model_step(input bit clr);
        bit v_enc[6], v_conf[6], v_seq[6], v_dw[6];
        bit any_v, old_fault;
        int new_id;
        for (int i = 0; i < 6; i++) begin
            v_enc[i] = !is_legal(s_code[i]);
            v_conf[i] = 0; v_seq[i] = 0; v_dw[i] = 0;
        end
        for (int p = 0; p < 8; p++)
            if (is_lit(s_code[pair_a[p]]) && is_lit(s_code[pair_b[p]])) v_conf[pair_a[p]] = 1;
        for (int i = 0; i < 6; i++) begin
            if (v_enc[i]) continue;
            if (!m_armed) begin
                m_prev[i] = s_code[i];
                m_cnt[i]  = 1;
            end else if (s_code[i] == m_prev[i]) begin
                if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
            end else begin
                case ({m_prev[i], s_code[i]})
                    6'b100_001: ;
                    6'b001_010: v_dw[i] = (m_cnt[i] < MIN_GREEN);
                    6'b010_100: v_dw[i] = (m_cnt[i] < MIN_YELLOW);
                    default:    v_seq[i] = 1;
                endcase
                m_prev[i] = s_code[i];
                m_cnt[i]  = 1;
            end
        end
        m_armed = 1;
        new_id = 7;
        for (int i = 5; i >= 0; i--) if (v_dw[i])   new_id = i;
        for (int i = 5; i >= 0; i--) if (v_seq[i])  new_id = i;
        for (int i = 5; i >= 0; i--) if (v_conf[i]) new_id = i;
        for (int i = 5; i >= 0; i--) if (v_enc[i])  new_id = i;
        any_v = (new_id != 7);
        if (clr) begin
            m_enc = 0; m_seq = 0; m_dw = 0; m_conf = 0; m_id = 7; m_count = 0;
        end
        old_fault = (m_enc | m_seq | m_dw | m_conf) != 0;
        for (int i = 0; i < 6; i++) begin
            if (v_enc[i])  m_enc = 1;
            if (v_seq[i])  m_seq = 1;
            if (v_dw[i])   m_dw = 1;
            if (v_conf[i]) m_conf = 1;
        end
        if (any_v && !old_fault) m_id = new_id;
        if (any_v && m_count < 255) m_count++;
    endtask

    // Drive one cycle at a falling edge, predict the post-edge state, wait for the next falling edge
    task automatic step(input bit clr);
        exp_t e;
        clr_err = clr;
        model_step(clr);
        e.enc = m_enc; e.seq = m_seq; e.dw = m_dw; e.conf = m_conf;
        e.flt = m_enc | m_seq | m_dw | m_conf; e.id = m_id; e.cnt = m_count;
        sb_q.push_back(e);
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic all_red();
        for (int i = 0; i < 6; i++) s_code[i] = 3'b100;
    endtask

    task automatic expect_state(input string tag, input int enc, input int seq, input int dw,
                                input int conf, input int id, input int cnt);
        check_eq({tag, "_enc"},  err_encoding, enc);
        check_eq({tag, "_seq"},  err_sequence, seq);
        check_eq({tag, "_dwell"}, err_dwell, dw);
        check_eq({tag, "_conf"}, err_conflict, conf);
        check_eq({tag, "_fault"}, fault, (enc | seq | dw | conf));
        check_eq({tag, "_id"},   fault_id, id);
        check_eq({tag, "_cnt"},  err_count, cnt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        expect_state("reset", 0, 0, 0, 0, 7, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check_eq("sb_enc",   err_encoding, mon_e.enc);
            check_eq("sb_seq",   err_sequence, mon_e.seq);
            check_eq("sb_dwell", err_dwell, mon_e.dw);
            check_eq("sb_conf",  err_conflict, mon_e.conf);
            check_eq("sb_fault", fault, mon_e.flt);
            check_eq("sb_id",    fault_id, mon_e.id);
            check_eq("sb_cnt",   err_count, mon_e.cnt);
        end
    end

    initial begin
        all_red();
        model_reset();
        @(negedge clk);

        // 1: legal R->G->Y->R on index 0
        do_reset();
        repeat (3) step(0);
        s_code[0] = 3'b001; repeat (5) step(0);
        s_code[0] = 3'b010; repeat (2) step(0);
        s_code[0] = 3'b100; repeat (2) step(0);
        expect_state("legal", 0, 0, 0, 0, 7, 0);

        // 2: short green on index 1
        do_reset();
        repeat (2) step(0);
        s_code[1] = 3'b001; repeat (3) step(0);
        s_code[1] = 3'b010; step(0);
        expect_state("short_green", 0, 0, 1, 0, 1, 1);

        // 3: conflict between 0 and 5
        do_reset();
        all_red(); step(0);
        s_code[0] = 3'b001; s_code[5] = 3'b001; repeat (4) step(0);
        expect_state("conflict", 0, 0, 0, 1, 0, 4);

        // 4: illegal G->R on index 2 with bad code on index 4
        do_reset();
        all_red(); step(0);
        s_code[2] = 3'b001; step(0);
        s_code[2] = 3'b100; s_code[4] = 3'b011; step(0);
        expect_state("seq_enc", 1, 1, 0, 0, 4, 1);

        // 5: saturation, clear, clear colliding with a violation
        do_reset();
        all_red(); step(0);
        s_code[0] = 3'b001; s_code[5] = 3'b001; repeat (300) step(0);
        expect_state("saturate", 0, 0, 0, 1, 0, 255);
        s_code[0] = 3'b010; s_code[5] = 3'b010; repeat (2) step(0);
        all_red(); step(0);
        step(1);
        expect_state("clear", 0, 0, 0, 0, 7, 0);
        s_code[4] = 3'b111; step(1);
        expect_state("clear_vs_viol", 1, 0, 0, 0, 4, 1);

        // 6: reset while index 3 is yellow, restart on green
        do_reset();
        all_red(); step(0);
        s_code[3] = 3'b001; repeat (5) step(0);
        s_code[3] = 3'b010; step(0);
        s_code[3] = 3'b001;
        do_reset();
        repeat (5) step(0);
        s_code[3] = 3'b010; repeat (2) step(0);
        s_code[3] = 3'b100; step(0);
        expect_state("rearm", 0, 0, 0, 0, 7, 0);

        check_eq("sb_drain", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the receiving end of the six 3-bit lamp buses driven by traffic_controller at the T-junction.
- Samples all six lamp codes every clock and checks four rules: legal encoding, legal R->G->Y->R sequencing, minimum green/yellow dwell, and no simultaneous non-red on conflicting movements.
- Raises sticky error flags and keeps a saturating error count; used in simulation benches and as an on-chip safety watchdog.

Parameters:
MIN_GREEN, 5, minimum cycles a green code must be held before changing to yellow
MIN_YELLOW, 2, minimum cycles a yellow code must be held before changing to red
CNT_W, 8, width of per-signal dwell counters (saturate at all-ones)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
w_to_e  in  3  lamp code, index 0
w_to_n  in  3  lamp code, index 1
e_to_w  in  3  lamp code, index 2
e_to_n  in  3  lamp code, index 3
n_to_e  in  3  lamp code, index 4
n_to_w  in  3  lamp code, index 5
clr_err  in  1  synchronous clear of all flags, fault_id and err_count
err_encoding  out  1  sticky: some code was not one-hot
err_sequence  out  1  sticky: illegal colour transition
err_dwell  out  1  sticky: green/yellow left too early
err_conflict  out  1  sticky: conflicting movements both non-red
fault  out  1  OR of the four sticky flags
fault_id  out  3  index (0-5) of the signal behind the first fault; 7 = none
err_count  out  8  count of cycles with at least one violation, saturates at 255

Behaviour:
- Lamp encoding: bit2 = red, bit1 = yellow, bit0 = green. Legal codes are 100, 010 and 001 only.
- Reset (async, rst=1): all err_* = 0, fault = 0, fault_id = 7, err_count = 0, armed = 0. prev[i] = 100 and cnt[i] = 0 for every signal.
- Every rising edge samples the live inputs. Checks are combinational on the live inputs against prev[]. Flags update at the same edge, so latency is 1 edge from applying a violation to the flag going high.
- Encoding check: any input not in the legal set -> err_encoding. prev[i] and cnt[i] are not updated for that signal that cycle.
- Conflict check (non-red = yellow or green) on these fixed pairs:
  - (0,3), (0,4), (0,5)
  - (1,2), (1,3), (1,5)
  - (2,5), (3,5)
  - Any pair both non-red -> err_conflict. fault_id takes the lower index of the pair.
- Sequence check, only when armed = 1 and input != prev:
  - Legal changes: 100->001, 001->010, 010->100.
  - Any other change -> err_sequence.
- Dwell counters:
  - cnt[i] = number of consecutive sampled cycles at prev[i], starting at 1; saturates.
  - On a legal 001->010 change with cnt < MIN_GREEN -> err_dwell.
  - On a legal 010->100 change with cnt < MIN_YELLOW -> err_dwell.
  - On any change, cnt[i] reloads to 1.
  - Red has no minimum dwell.
- Arming: the first edge after reset deassertion loads prev[] from the inputs with sequence and dwell checks suppressed, then sets armed = 1. Encoding and conflict checks are active from that first edge.
- Sticky flags stay set until rst or clr_err.
- fault_id latches only on the 0->1 transition of fault.
  - Simultaneous violations in one cycle: the lowest offending signal index wins.
  - Category priority is encoding > conflict > sequence > dwell.
- err_count increments by 1 per cycle with any violation (not per violation) and holds at 255.
- clr_err = 1:
  - Clears flags, fault_id (to 7) and err_count at that edge.
  - A violation in the same cycle wins: its flag sets, count becomes 1, fault_id takes the new index.
  - prev[], cnt[] and armed are not affected.
- Reset mid-operation clears everything immediately and forces re-arming. The first post-reset sample is never flagged as a sequence or dwell error.

Test Plan:
1. Legal cycle: index 0 runs R(3)->G(5)->Y(2)->R, all others at 100 -> all flags 0, err_count 0, fault_id 7.
2. Short green: w_to_n goes G for 3 cycles then Y, MIN_GREEN=5 -> err_dwell=1 one edge after Y is applied, fault_id=1, err_count=1.
3. Conflict: w_to_e=001 and n_to_w=001 for 4 cycles -> err_conflict=1, fault_id=0, err_count=4.
4. Illegal sequence plus bad encoding in the same cycle: e_to_w goes 001->100 while n_to_e=011 -> err_sequence=1, err_encoding=1, fault_id=4 (encoding priority), err_count=1.
5. Saturation and clear: hold a conflict for 300 cycles -> err_count=255. Pulse clr_err with no violation -> all flags 0, fault_id=7, count 0.
6. Reset mid-run: assert rst while index 3 is yellow, release with index 3 at 001 -> no sequence error on the first sample. A later 001->010 after 5 greens gives no error.
